// File: rtl/ysyx_22050710_axi4full_sram_slave.sv
// ysyx_22050710_axi4full_sram_slave: AXI4 full INCR-burst slave over a byte-enabled word SRAM
module ysyx_22050710_axi4full_sram_slave #(
  parameter int DATA_WIDTH = 64,
  parameter int MEM_DEPTH  = 1024,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  i_aclk,
  input  logic                  i_areset,
  input  logic [3:0]            i_awid,
  input  logic [31:0]           i_awaddr,
  input  logic [7:0]            i_awlen,
  input  logic                  i_awvalid,
  output logic                  o_awready,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [STRB_WIDTH-1:0] i_wstrb,
  input  logic                  i_wlast,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [3:0]            o_bid,
  output logic [1:0]            o_bresp,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  input  logic [3:0]            i_arid,
  input  logic [31:0]           i_araddr,
  input  logic [7:0]            i_arlen,
  input  logic                  i_arvalid,
  output logic                  o_arready,
  output logic [3:0]            o_rid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [1:0]            o_rresp,
  output logic                  o_rlast,
  output logic                  o_rvalid,
  input  logic                  i_rready
);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam int OW = $clog2(STRB_WIDTH);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;
  logic [3:0] w_id_q, w_id_d, r_id_q, r_id_d;
  logic [IW-1:0] w_idx_q, w_idx_d, r_idx_q, r_idx_d, r_nxt;
  logic [7:0] w_len_q, w_len_d, w_cnt_q, w_cnt_d, r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic w_err_q, w_err_d, w_fire, w_end, r_end;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic unused;
  assign unused = ^{i_awaddr, i_araddr};
  assign o_awready = w_state_q == W_IDLE;
  assign o_wready = w_state_q == W_DATA;
  assign o_bvalid = w_state_q == W_RESP;
  assign o_bid = w_id_q;
  assign o_bresp = {o_bvalid && w_err_q, 1'b0};
  assign o_arready = r_state_q == R_IDLE;
  assign o_rvalid = r_state_q == R_DATA;
  assign o_rlast = o_rvalid && r_end;
  assign o_rid = r_id_q;
  assign o_rdata = rdata_q;
  assign o_rresp = 2'b00;
  assign w_fire = o_wready && i_wvalid;
  assign w_end = w_cnt_q == w_len_q;
  assign r_end = r_cnt_q == r_len_q;
  assign r_nxt = r_idx_q + 1'b1;
  always_comb begin
    w_state_d = w_state_q;
    w_id_d = w_id_q;
    w_idx_d = w_idx_q;
    w_len_d = w_len_q;
    w_cnt_d = w_cnt_q;
    w_err_d = w_err_q;
    unique case (w_state_q)
      W_IDLE: if (i_awvalid) begin
        w_id_d = i_awid;
        w_idx_d = i_awaddr[OW +: IW];
        w_len_d = i_awlen;
        w_cnt_d = 8'd0;
        w_err_d = 1'b0;
        w_state_d = W_DATA;
      end
      W_DATA: if (i_wvalid) begin
        w_idx_d = w_idx_q + 1'b1;
        w_cnt_d = w_cnt_q + 8'd1;
        w_err_d = w_err_q | (i_wlast != w_end);
        w_state_d = w_end ? W_RESP : W_DATA;
      end
      W_RESP: w_state_d = i_bready ? W_IDLE : W_RESP;
      default: w_state_d = W_IDLE;
    endcase
  end
  always_comb begin
    r_state_d = r_state_q;
    r_id_d = r_id_q;
    r_idx_d = r_idx_q;
    r_len_d = r_len_q;
    r_cnt_d = r_cnt_q;
    rdata_d = rdata_q;
    unique case (r_state_q)
      R_IDLE: if (i_arvalid) begin
        r_id_d = i_arid;
        r_idx_d = i_araddr[OW +: IW];
        r_len_d = i_arlen;
        r_cnt_d = 8'd0;
        rdata_d = mem[i_araddr[OW +: IW]];
        r_state_d = R_DATA;
      end
      R_DATA: if (i_rready) begin
        r_idx_d = r_nxt;
        r_cnt_d = r_cnt_q + 8'd1;
        rdata_d = r_end ? rdata_q : mem[r_nxt];
        r_state_d = r_end ? R_IDLE : R_DATA;
      end
      default: r_state_d = R_IDLE;
    endcase
  end
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      w_state_q <= W_IDLE;
      w_id_q <= '0;
      w_idx_q <= '0;
      w_len_q <= '0;
      w_cnt_q <= '0;
      w_err_q <= 1'b0;
      r_state_q <= R_IDLE;
      r_id_q <= '0;
      r_idx_q <= '0;
      r_len_q <= '0;
      r_cnt_q <= '0;
      rdata_q <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q <= w_id_d;
      w_idx_q <= w_idx_d;
      w_len_q <= w_len_d;
      w_cnt_q <= w_cnt_d;
      w_err_q <= w_err_d;
      r_state_q <= r_state_d;
      r_id_q <= r_id_d;
      r_idx_q <= r_idx_d;
      r_len_q <= r_len_d;
      r_cnt_q <= r_cnt_d;
      rdata_q <= rdata_d;
    end
  end
  always_ff @(posedge i_aclk) begin
    if (w_fire) begin
      for (int k = 0; k < STRB_WIDTH; k++) begin
        if (i_wstrb[k]) mem[w_idx_q][k*8 +: 8] <= i_wdata[k*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_ysyx_22050710_axi4full_sram_slave.sv
// tb_ysyx_22050710_axi4full_sram_slave: scoreboard bench with a word-array memory model
module tb_ysyx_22050710_axi4full_sram_slave;
  localparam int DEPTH = 1024;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] awid, arid, bid, rid;
  logic [31:0] awaddr, araddr;
  logic [7:0] awlen, arlen, wstrb;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [63:0] wdata, rdata;
  logic [1:0] bresp, rresp;
  typedef struct {logic [3:0] id; logic [63:0] data; logic last;} rexp_t;
  typedef struct {logic [3:0] id; logic [1:0] resp;} bexp_t;
  rexp_t rq[$];
  bexp_t bq[$];
  logic [63:0] ref_mem [DEPTH];
  int checks = 0, passes = 0, rmode = 0;
  always #5 clk = ~clk;
  ysyx_22050710_axi4full_sram_slave dut (
    .i_aclk(clk), .i_areset(rst),
    .i_awid(awid), .i_awaddr(awaddr), .i_awlen(awlen), .i_awvalid(awvalid), .o_awready(awready),
    .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid), .o_wready(wready),
    .o_bid(bid), .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
    .i_arid(arid), .i_araddr(araddr), .i_arlen(arlen), .i_arvalid(arvalid), .o_arready(arready),
    .o_rid(rid), .o_rdata(rdata), .o_rresp(rresp), .o_rlast(rlast), .o_rvalid(rvalid), .i_rready(rready)
  );
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", n, got, exp);
  endtask
  initial begin
    rready = 1'b1;
    bready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rready = rmode == 0 ? 1'b1 : rmode == 1 ? ~rready : 1'($urandom);
      bready = rmode == 0 ? 1'b1 : 1'($urandom);
    end
  end
  initial begin
    logic pstall, pbstall, plast;
    logic [63:0] pdata;
    logic [3:0] pid, pbid;
    logic [1:0] pbresp;
    rexp_t re;
    bexp_t be;
    pstall = 0;
    pbstall = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pstall = 0;
        pbstall = 0;
      end else begin
        if (pstall) begin
          chk("r_hold_valid", 64'(rvalid), 64'd1);
          chk("r_hold_data", rdata, pdata);
          chk("r_hold_last", 64'(rlast), 64'(plast));
          chk("r_hold_id", 64'(rid), 64'(pid));
        end
        if (pbstall) begin
          chk("b_hold_valid", 64'(bvalid), 64'd1);
          chk("b_hold_id", 64'(bid), 64'(pbid));
          chk("b_hold_resp", 64'(bresp), 64'(pbresp));
        end
        if (rvalid) chk("arready_busy", 64'(arready), 64'd0);
        if (rvalid && rready) begin
          chk("r_expected", 64'(rq.size() > 0), 64'd1);
          if (rq.size() > 0) begin
            re = rq.pop_front();
            chk("rid", 64'(rid), 64'(re.id));
            chk("rdata", rdata, re.data);
            chk("rlast", 64'(rlast), 64'(re.last));
            chk("rresp", 64'(rresp), 64'd0);
          end
        end
        if (bvalid && bready) begin
          chk("b_expected", 64'(bq.size() > 0), 64'd1);
          if (bq.size() > 0) begin
            be = bq.pop_front();
            chk("bid", 64'(bid), 64'(be.id));
            chk("bresp", 64'(bresp), 64'(be.resp));
          end
        end
        pstall = rvalid && !rready;
        pdata = rdata;
        plast = rlast;
        pid = rid;
        pbstall = bvalid && !bready;
        pbid = bid;
        pbresp = bresp;
      end
    end
  end
  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input int len, input int lmode,
                             input logic [63:0] d, input logic [7:0] s, input bit rd, input bit rs);
    int n, idx;
    logic err, lb;
    logic [63:0] bd;
    logic [7:0] bs;
    err = 0;
    for (int b = 0; b <= len; b++) begin
      lb = lmode == 1 ? (b == 0) : lmode == 2 ? 1'b0 : (b == len);
      err |= lb != (b == len);
    end
    bq.push_back('{id, err ? 2'b10 : 2'b00});
    idx = int'(addr >> 3) % DEPTH;
    awid = id;
    awaddr = addr;
    awlen = 8'(len);
    awvalid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 1000);
    if (!awready) chk("aw_timeout", 64'(awready), 64'd1);
    @(posedge clk);
    #1 awvalid = 0;
    for (int b = 0; b <= len; b++) begin
      if (rd) repeat ($urandom % 2) begin @(posedge clk); #1; end
      bd = rd ? {$urandom, $urandom} : d;
      bs = rs ? 8'($urandom) : s;
      wdata = bd;
      wstrb = bs;
      wlast = lmode == 1 ? (b == 0) : lmode == 2 ? 1'b0 : (b == len);
      wvalid = 1;
      n = 0;
      do begin @(negedge clk); n++; end while (!wready && n < 1000);
      if (!wready) chk("w_timeout", 64'(wready), 64'd1);
      for (int k = 0; k < 8; k++) if (bs[k]) ref_mem[(idx + b) % DEPTH][k*8 +: 8] = bd[k*8 +: 8];
      @(posedge clk);
      #1 wvalid = 0;
    end
  endtask
  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input int len);
    int n, idx;
    idx = int'(addr >> 3) % DEPTH;
    for (int b = 0; b <= len; b++) rq.push_back('{id, ref_mem[(idx + b) % DEPTH], b == len});
    arid = id;
    araddr = addr;
    arlen = 8'(len);
    arvalid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 1000);
    if (!arready) chk("ar_timeout", 64'(arready), 64'd1);
    @(posedge clk);
    #1 arvalid = 0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() > 0 || bq.size() > 0) && n < 5000) begin @(posedge clk); n++; end
    if (n >= 5000) chk("drain_timeout", 64'(rq.size() + bq.size()), 64'd0);
    #1;
  endtask
  task automatic reset_checks();
    chk("rst_awready", 64'(awready), 64'd1);
    chk("rst_arready", 64'(arready), 64'd1);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rlast", 64'(rlast), 64'd0);
    chk("rst_bresp", 64'(bresp), 64'd0);
    chk("rst_rresp", 64'(rresp), 64'd0);
    chk("rst_bid", 64'(bid), 64'd0);
    chk("rst_rid", 64'(rid), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
  endtask
  initial begin
    awid = 0; awaddr = 0; awlen = 0; awvalid = 0;
    wdata = 0; wstrb = 0; wlast = 0; wvalid = 0;
    arid = 0; araddr = 0; arlen = 0; arvalid = 0;
    repeat (3) @(posedge clk);
    #1 reset_checks();
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 4; i++) write_burst(4'(i), 32'(i * 256 * 8), 255, 0, 64'd0, 8'hFF, 1, 0);
    drain();
    read_burst(4'd1, 32'h0, 255);
    drain();
    write_burst(4'd3, 32'h10, 3, 0, 64'd0, 8'hFF, 1, 0);
    read_burst(4'd5, 32'h10, 3);
    drain();
    write_burst(4'd1, 32'h0, 0, 0, '1, 8'hFF, 0, 0);
    write_burst(4'd2, 32'h0, 0, 0, 64'h1122334455667788, 8'h0F, 0, 0);
    drain();
    chk("model_partial_strb", ref_mem[0], 64'hFFFFFFFF55667788);
    read_burst(4'd7, 32'h0, 0);
    drain();
    write_burst(4'd4, 32'h100, 1, 1, 64'd0, 8'hFF, 1, 0);
    read_burst(4'd4, 32'h100, 1);
    drain();
    write_burst(4'd6, 32'h200, 2, 2, 64'd0, 8'hFF, 1, 0);
    read_burst(4'd6, 32'h200, 2);
    drain();
    rmode = 1;
    read_burst(4'd9, 32'h300, 7);
    drain();
    rmode = 2;
    for (int i = 0; i < 12; i++) begin
      write_burst(4'($urandom), $urandom, int'($urandom % 16), int'($urandom % 4) % 3, 64'd0, 8'd0, 1, 1);
      read_burst(4'($urandom), $urandom, int'($urandom % 16));
      drain();
    end
    rmode = 0;
    read_burst(4'd2, 32'((DEPTH - 1) * 8), 1);
    drain();
    read_burst(4'd3, 32'((DEPTH - 2) * 8), 7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1;
    #1 reset_checks();
    rq.delete();
    @(posedge clk);
    #1 rst = 0;
    read_burst(4'd8, 32'((DEPTH - 2) * 8), 3);
    drain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ysyx_22050710_axi4full_sram_slave.md
YSYX_22050710_AXI4FULL_SRAM_SLAVE -- requirements
Module: ysyx_22050710_axi4full_sram_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, bus width in bits; STRB_WIDTH = DATA_WIDTH/8.
REQ-002 SHALL have parameter MEM_DEPTH, default 1024, storage size in DATA_WIDTH words (power of two).
REQ-003 SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-004 i_aclk  in  1  clock; all logic on rising edge.
REQ-005 i_areset  in  1  asynchronous active-high reset.
REQ-006 i_awid  in  4  write burst ID.
REQ-007 i_awaddr  in  32  write start byte address.
REQ-008 i_awlen  in  8  write beats minus one.
REQ-009 i_awvalid  in  1  AW valid.
REQ-010 o_awready  out  1  AW ready.
REQ-011 i_wdata  in  DATA_WIDTH  write data.
REQ-012 i_wstrb  in  STRB_WIDTH  byte enables.
REQ-013 i_wlast  in  1  final write beat marker.
REQ-014 i_wvalid  in  1  W valid.
REQ-015 o_wready  out  1  W ready.
REQ-016 o_bid  out  4  echoed AW ID.
REQ-017 o_bresp  out  2  write response.
REQ-018 o_bvalid  out  1  B valid.
REQ-019 i_bready  in  1  B ready.
REQ-020 i_arid  in  4  read burst ID.
REQ-021 i_araddr  in  32  read start byte address.
REQ-022 i_arlen  in  8  read beats minus one.
REQ-023 i_arvalid  in  1  AR valid.
REQ-024 o_arready  out  1  AR ready.
REQ-025 o_rid  out  4  echoed AR ID.
REQ-026 o_rdata  out  DATA_WIDTH  read data.
REQ-027 o_rresp  out  2  read response, always 2'b00.
REQ-028 o_rlast  out  1  final read beat marker.
REQ-029 o_rvalid  out  1  R valid.
REQ-030 i_rready  in  1  R ready.

Function
REQ-031 All bursts SHALL be INCR, full bus width. Word index = addr[log2(STRB_WIDTH) +: log2(MEM_DEPTH)]; +1 per beat; wraps modulo MEM_DEPTH.
REQ-032 Write FSM SHALL be W_IDLE/W_DATA/W_RESP: o_awready=1 only in W_IDLE; AW handshake latches id, word index, len, clears 8-bit beat counter and error flag, goes W_DATA.
REQ-033 In W_DATA o_wready SHALL be 1; each W handshake writes bytes with i_wstrb[k]=1, increments index and counter; beat where counter==len moves to W_RESP next cycle.
REQ-034 i_wlast mismatch (high before beat len, or low on beat len) SHALL set error flag; burst length is always governed by len.
REQ-035 In W_RESP o_bvalid=1, o_bid=latched id, o_bresp=2'b10 if error flag else 2'b00; B handshake returns to W_IDLE; outputs held stable until i_bready.
REQ-036 Read FSM SHALL be R_IDLE/R_DATA: o_arready=1 only in R_IDLE; AR handshake latches id, index, len, goes R_DATA with o_rvalid=1 the next cycle carrying word at start index (one-cycle latency).
REQ-037 While o_rvalid=1 and i_rready=0, o_rdata/o_rlast/o_rid SHALL hold stable; each R handshake presents the next word the following cycle with no bubble.
REQ-038 o_rlast=1 exactly on beat len; its handshake returns to R_IDLE (o_rvalid=0 next cycle).
REQ-039 Read and write FSMs SHALL run concurrently; same-word write and read in one cycle returns old data (read-before-write).
REQ-040 len=0 SHALL be a one-beat burst; len=255 SHALL complete 256 beats (counter must not overflow early).

Reset
REQ-041 While i_areset=1: FSMs in IDLE, o_awready=1, o_arready=1, o_wready=0, o_bvalid=0, o_rvalid=0, o_rlast=0, o_bresp=0, o_rresp=0, o_bid=0, o_rid=0, o_rdata=0; mid-burst reset abandons the burst; memory contents not reset.

Verification
REQ-042 AW id=3 addr=0x10 len=3, 4 W beats strb=0xFF wlast on 4th -> bvalid, bid=3, bresp=00; AR id=5 same burst -> 4 beats echo data, rid=5, rlast on beat 4 only.
REQ-043 Write 0x1122334455667788 strb=0x0F to word 0 previously all-ones -> read returns 0xFFFFFFFF55667788.
REQ-044 len=1 with wlast on beat 1 -> bresp=10; both beats still written.
REQ-045 Read len=7 with i_rready toggling 1010... -> data stable during stalls, 8 beats in order, arready low until last handshake.
REQ-046 Read addr=(MEM_DEPTH-1)*8 len=1 -> beat 2 returns word 0; assert i_areset mid-read burst -> rvalid=0 same cycle, arready=1.
